// File: rtl/romload_stream.sv
// romload_stream: CPU-fed ROM-load byte path.
//
// The softcore writes 32-bit words (with byte strobes) to a data register.
// The words are buffered in a DEPTH-entry FIFO and unpacked little-endian into
// OUT_W-bit beats on a valid/ready stream. Only lanes whose byte strobes are
// all set are emitted. A load-mode control write is held off via reg_wait until
// the FIFO and the unpacker are empty, so every beat leaves under the mode it
// was written in.
//
// Optional feature: define ROMLOAD_STREAM_CSUM_EN to add a 16-bit running sum
// of emitted bytes in reg_do[31:16]. Without it those bits read as zero.
//
// Ports:
//   clk, resetn    system clock, synchronous active-low reset
//   reg_data_we    byte strobes of a data-register write (nonzero = write)
//   reg_ctrl_we    control-register write (mode = reg_di[MODE_W-1:0])
//   reg_di         CPU write data
//   reg_wait       stall of the current CPU access (combinational)
//   reg_do         {checksum, FIFO level, busy, 0..., mode}
//   mode           current load mode
//   out_data       stream beat, little-endian lane order
//   out_valid      beat valid
//   out_ready      consumer accepts the beat
//   byte_cnt       bytes emitted since the last mode change
//   busy           FIFO non-empty or unpacker holding a word
module romload_stream #(
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 8,
  parameter int MODE_W = 3,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        reg_data_we,
  input  logic              reg_ctrl_we,
  input  logic [31:0]       reg_di,
  output logic              reg_wait,
  output logic [31:0]       reg_do,
  output logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              busy
);

  localparam int LANES = 32 / OUT_W;
  localparam int BPL   = OUT_W / 8;
  localparam int AW    = $clog2(DEPTH);

  // FIFO entries are {word, strobes}
  logic [35:0]      mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      level;
  logic [35:0]      head;
  logic [LANES-1:0] head_mask;

  // Unpacker: the held word plus the set of lanes still to be emitted.
  logic [31:0]      word_q;
  logic [LANES-1:0] mask_q;

  logic fifo_empty;
  logic fifo_full;
  logic idle;
  logic push;
  logic pop;
  logic xfer;
  logic last_lane;
  logic ctrl_ok;
  logic [15:0] csum_out;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (AW+1)'(DEPTH));
  assign out_valid  = |mask_q;
  assign idle       = fifo_empty && !out_valid;
  assign busy       = !idle;
  assign xfer       = out_valid && out_ready;
  // The beat being transferred is the only lane left in the held word.
  assign last_lane  = xfer && ((mask_q & (mask_q - LANES'(1))) == '0);
  // A push is refused on a full FIFO even if a pop frees a slot this cycle.
  assign push       = (reg_data_we != 4'b0) && !fifo_full;
  assign pop        = !fifo_empty && (!out_valid || last_lane);
  assign ctrl_ok    = reg_ctrl_we && idle;
  assign reg_wait   = ((reg_data_we != 4'b0) && fifo_full) || (reg_ctrl_we && !idle);

  assign head = mem[rptr];

  always_comb begin
    head_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      head_mask[i] = &head[i*BPL +: BPL];
    end
  end

  // Current beat is the lowest lane still pending.
  always_comb begin
    out_data = word_q[OUT_W-1:0];
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        out_data = word_q[i*OUT_W +: OUT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem[wptr] <= {reg_di, reg_data_we};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      word_q   <= '0;
      mask_q   <= '0;
      mode     <= '0;
      byte_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A word with no emittable lanes loads an empty mask and is gone.
      if (pop) begin
        word_q <= head[35:4];
        mask_q <= head_mask;
      end else if (xfer) begin
        mask_q <= mask_q & (mask_q - LANES'(1));
      end
      if (ctrl_ok) begin
        mode     <= reg_di[MODE_W-1:0];
        byte_cnt <= '0;
      end else if (xfer) begin
        byte_cnt <= byte_cnt + CNT_W'(BPL);
      end
    end
  end

`ifdef ROMLOAD_STREAM_CSUM_EN
  logic [15:0] csum;
  logic [15:0] beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < BPL; i++) begin
      beat_sum = beat_sum + 16'(out_data[i*8 +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || ctrl_ok) begin
      csum <= '0;
    end else if (xfer) begin
      csum <= csum + beat_sum;
    end
  end

  assign csum_out = csum;
`else
  assign csum_out = 16'h0;
`endif

  assign reg_do = {csum_out, 8'(level), busy, {(7-MODE_W){1'b0}}, mode};

endmodule

// File: tb/tb_romload_stream.sv
module tb_romload_stream;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 8;
  localparam int MODE_W = 3;
  localparam int CNT_W  = 24;
  localparam int BPL    = OUT_W / 8;
  localparam int LANES  = 32 / OUT_W;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [3:0]        reg_data_we = 4'h0;
  logic              reg_ctrl_we = 1'b0;
  logic [31:0]       reg_di = 32'h0;
  logic              reg_wait;
  logic [31:0]       reg_do;
  logic [MODE_W-1:0] mode;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  byte_cnt;
  logic              busy;

  always #5 clk = ~clk;

  romload_stream #(.OUT_W(OUT_W), .DEPTH(DEPTH), .MODE_W(MODE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .reg_data_we(reg_data_we), .reg_ctrl_we(reg_ctrl_we),
    .reg_di(reg_di), .reg_wait(reg_wait), .reg_do(reg_do), .mode(mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .byte_cnt(byte_cnt), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: beats still owed to the consumer, in order.
  logic [OUT_W-1:0]  exp_q[$];
  logic [MODE_W-1:0] mode_m = '0;
  logic [CNT_W-1:0]  cnt_m = '0;
  logic [15:0]       csum_m = '0;
  bit acc_data, acc_ctrl, rand_rdy, prev_stall;
  logic [MODE_W-1:0] last_xfer_mode = '0;
  logic              last_xfer_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] csum_exp();
`ifdef ROMLOAD_STREAM_CSUM_EN
    return csum_m;
`else
    return 16'h0;
`endif
  endfunction

  // One clock: sample mid-cycle, update the model for what the coming edge
  // does, then return 1 time unit after the edge.
  task automatic tick();
    logic [OUT_W-1:0] b;
    #3;
    chk("mode", 32'(mode), 32'(mode_m));
    chk("byte_cnt", 32'(byte_cnt), 32'(cnt_m));
    chk("reg_do_mode", 32'(reg_do[MODE_W-1:0]), 32'(mode_m));
    chk("csum", 32'(reg_do[31:16]), 32'(csum_exp()));
    chk("level_le_depth", 32'(reg_do[15:8] <= 8'(DEPTH)), 32'd1);
    if (prev_stall) chk("valid_hold", 32'(out_valid), 32'd1);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("beat_available", 32'(exp_q.size() != 0), 32'd1);
      else chk("out_data", 32'(out_data), 32'(exp_q[0]));
    end
    acc_data = resetn && (reg_data_we != 4'h0) && !reg_wait;
    acc_ctrl = resetn && reg_ctrl_we && !reg_wait;
    if (!resetn) begin
      exp_q.delete();
      mode_m = '0;
      cnt_m = '0;
      csum_m = '0;
      prev_stall = 1'b0;
    end else begin
      if (acc_ctrl) begin
        chk("ctrl_after_drain", 32'(exp_q.size()), 32'd0);
        mode_m = reg_di[MODE_W-1:0];
        cnt_m = '0;
        csum_m = '0;
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        cnt_m = cnt_m + CNT_W'(BPL);
        for (int k = 0; k < BPL; k++) csum_m = csum_m + 16'(b[k*8 +: 8]);
        last_xfer_mode = mode;
        last_xfer_busy = busy;
      end
      prev_stall = out_valid && !out_ready;
      if (acc_data) begin
        for (int i = 0; i < LANES; i++) begin
          if (&reg_data_we[i*BPL +: BPL]) exp_q.push_back(reg_di[i*OUT_W +: OUT_W]);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic write_data(input logic [31:0] w, input logic [3:0] s, output int waits);
    int n;
    n = 0;
    reg_di = w;
    reg_data_we = s;
    do begin
      tick();
      n++;
    end while (!acc_data && n < 300);
    chk("write_done", 32'(acc_data), 32'd1);
    waits = n - 1;
    reg_data_we = 4'h0;
  endtask

  task automatic ctrl_write(input logic [31:0] v, output int waits);
    int n;
    n = 0;
    reg_di = v;
    reg_ctrl_we = 1'b1;
    do begin
      tick();
      n++;
    end while (!acc_ctrl && n < 300);
    chk("ctrl_done", 32'(acc_ctrl), 32'd1);
    waits = n - 1;
    reg_ctrl_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg_do", reg_do, 32'd0);
    chk("rst_reg_wait", 32'(reg_wait), 32'd0);
    resetn = 1'b1;

    // Basic word: four consecutive beats, first beat two cycles after write.
    out_ready = 1'b1;
    ctrl_write(32'd1, w);
    chk("ctrl_idle_nowait", 32'(w), 32'd0);
    write_data(32'h44332211, 4'hF, w);
    chk("lat_valid_c1", 32'(out_valid), 32'd0);
    chk("lat_busy_c1", 32'(busy), 32'd1);
    tick();
    chk("lat_valid_c2", 32'(out_valid), 32'd1);
    chk("first_beat", 32'(out_data), 32'h11);
    repeat (4) tick();
    chk("word_byte_cnt", 32'(byte_cnt), 32'd4);
    chk("word_done_valid", 32'(out_valid), 32'd0);
    chk("word_done_busy", 32'(busy), 32'd0);
    chk("word_mode", 32'(mode), 32'd1);

    // Partial strobes: only bytes 0 and 2 are emitted.
    write_data(32'hDDCCBBAA, 4'h5, w);
    drain();
    chk("partial_cnt", 32'(byte_cnt), 32'd6);

    // Fill: the unpacker absorbs one word, so DEPTH+1 writes go through
    // without a stall and the FIFO then reports DEPTH entries.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      write_data($urandom, 4'hF, w);
      chk("fill_nowait", 32'(w), 32'd0);
    end
    chk("fill_level", 32'(reg_do[15:8]), DEPTH);
    reg_di = $urandom;
    reg_data_we = 4'hF;
    repeat (3) begin
      tick();
      chk("full_stall", 32'(acc_data), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("one_beat_still_full", 32'(acc_data), 32'd0);
    out_ready = 1'b0;
    tick();
    chk("full_stall_again", 32'(acc_data), 32'd0);
    out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_data && n < 50);
    chk("full_write_done", 32'(acc_data), 32'd1);
    reg_data_we = 4'h0;
    drain();

    // Mode change while words are queued waits for the last beat.
    out_ready = 1'b0;
    repeat (3) write_data($urandom, 4'hF, w);
    out_ready = 1'b1;
    ctrl_write(32'd0, w);
    chk("ctrl_waited", 32'(w > 0), 32'd1);
    chk("last_beat_old_mode", 32'(last_xfer_mode), 32'd1);
    chk("ctrl0_mode", 32'(mode), 32'd0);
    chk("ctrl0_cnt", 32'(byte_cnt), 32'd0);

    // Toggling ready over two words (streamed in mode 2).
    ctrl_write(32'd2, w);
    out_ready = 1'b0;
    write_data($urandom, 4'hF, w);
    write_data($urandom, 4'hF, w);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      out_ready = (n % 2 == 0);
      tick();
      n++;
    end
    chk("toggle_cnt", 32'(byte_cnt), 32'd8);
    chk("busy_at_last_xfer", 32'(last_xfer_busy), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);
    ctrl_write(32'd2, w);
    chk("rewrite_clears_cnt", 32'(byte_cnt), 32'd0);

    // 300 bytes of 0xFF: 300*255 mod 2^16 = 0x2AD4.
    ctrl_write(32'd4, w);
    out_ready = 1'b1;
    repeat (75) write_data(32'hFFFFFFFF, 4'hF, w);
    drain();
    chk("ff300_cnt", 32'(byte_cnt), 32'd300);
`ifdef ROMLOAD_STREAM_CSUM_EN
    chk("ff300_csum", 32'(reg_do[31:16]), 32'h2AD4);
`else
    chk("ff300_csum", 32'(reg_do[31:16]), 32'h0);
`endif

    // Random traffic with random backpressure and occasional mode writes.
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 11) == 0) ctrl_write(32'($urandom_range(0, 4)), w);
      else write_data($urandom, 4'($urandom_range(1, 15)), w);
    end
    rand_rdy = 1'b0;
    drain();

    // Reset mid-stream flushes everything.
    ctrl_write(32'd3, w);
    out_ready = 1'b0;
    repeat (3) write_data($urandom, 4'hF, w);
    out_ready = 1'b1;
    repeat (2) tick();
    resetn = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_reg_do", reg_do, 32'd0);
    chk("midrst_cnt", 32'(byte_cnt), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    resetn = 1'b1;
    write_data(32'hA5C3_0F96, 4'hF, w);
    drain();
    chk("post_rst_cnt", 32'(byte_cnt), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
